// File: rtl/spi_mem_ctrl_cached.sv
// spi_mem_ctrl_cached: SPI READ/WRITE memory controller (1-4 bytes, mode 0, clk/2)
// with a direct-mapped one-word cache serving aligned instruction fetches.
module spi_mem_ctrl_cached #(
  parameter int ADDR_W = 24,
  parameter int CACHE_LINES = 8,
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs,
  input  logic              start_request,
  input  logic              is_write,
  input  logic              is_data_fetch,
  input  logic [2:0]        read_bytes,
  input  logic [ADDR_W-1:0] target_address,
  input  logic [31:0]       write_data,
  output logic [31:0]       fetched_instruction,
  output logic [31:0]       fetched_data,
  output logic              request_done,
  input  logic              cache_flush,
  output logic              cache_hit
);
  localparam int IW = $clog2(CACHE_LINES);
  localparam int LW = ADDR_W - 2;
  localparam int TW = LW - IW;
  localparam int HDR = 8 + ADDR_W;
  localparam int TXW = HDR + 32;
  localparam int BW = $clog2(TXW + 1);
  typedef enum logic [2:0] {IDLE, LOOKUP, CS_SETUP, SHIFT, CS_END, DONE} state_t;
  state_t state_q, state_d;
  logic start_prev_q, start_prev_d, wr_q, wr_d, df_q, df_d, abort_q, abort_d;
  logic cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d, hit_q, hit_d;
  logic [1:0] nm1_q, nm1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TXW-1:0] tx_q, tx_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic [31:0] result_q, result_d;
  logic [CACHE_LINES-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [CACHE_LINES];
  logic [TW-1:0] tag_d [CACHE_LINES];
  logic [31:0] data_q [CACHE_LINES];
  logic [31:0] data_d [CACHE_LINES];
  logic [LW-1:0] line_s, line_e;
  logic [IW-1:0] idx_s, idx_e;
  logic [TW-1:0] tag_s, tag_e;
  logic carry, hit_s, hit_e, cacheable, data_bit, last_bit;
  logic [31:0] rd_word;
  logic [7:0] byte_in;
  // first and last word lines touched by the request; the end line wraps with the address space
  assign line_s = addr_q[ADDR_W-1:2];
  assign carry = ({1'b0, addr_q[1:0]} + {1'b0, nm1_q}) > 3'd3;
  assign line_e = line_s + LW'(carry);
  assign idx_s = line_s[IW-1:0];
  assign tag_s = line_s[LW-1:IW];
  assign idx_e = line_e[IW-1:0];
  assign tag_e = line_e[LW-1:IW];
  assign hit_s = valid_q[idx_s] && tag_q[idx_s] == tag_s;
  assign hit_e = valid_q[idx_e] && tag_q[idx_e] == tag_e;
  assign cacheable = !wr_q && !df_q && nm1_q == 2'd3 && addr_q[1:0] == 2'd0;
  assign data_bit = bit_q >= BW'(HDR);
  assign last_bit = bit_q == BW'(HDR + 7) + BW'({nm1_q, 3'b000});
  // bytes arrive into the top of result; slide down so byte0 lands in [7:0]
  assign rd_word = result_q >> {~nm1_q, 3'b000};
  assign byte_in = {byte_q[6:0], miso};
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs = cs_q;
  assign request_done = done_q;
  assign cache_hit = hit_q;
  assign fetched_instruction = (start_request && !df_q && !wr_q) ? result_q : 32'h0;
  assign fetched_data = (start_request && df_q && !wr_q) ? result_q : 32'h0;
  always_comb begin
    state_d = state_q;
    start_prev_d = start_request;
    wr_d = wr_q;
    df_d = df_q;
    nm1_d = nm1_q;
    addr_d = addr_q;
    tx_d = tx_q;
    bit_d = bit_q;
    byte_d = byte_q;
    result_d = result_q;
    abort_d = (state_q == IDLE) ? 1'b0 : abort_q | !start_request;
    cs_d = cs_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    done_d = done_q;
    hit_d = 1'b0;
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (start_request && !start_prev_q) begin
        state_d = LOOKUP;
        wr_d = is_write;
        df_d = is_data_fetch;
        nm1_d = (read_bytes == 3'd0 || read_bytes > 3'd4) ? 2'd3 : 2'(read_bytes - 3'd1);
        addr_d = target_address;
        tx_d = {is_write ? CMD_WRITE : CMD_READ, target_address,
                is_write ? {write_data[7:0], write_data[15:8], write_data[23:16], write_data[31:24]} : 32'h0};
        result_d = 32'h0;
      end
      LOOKUP: if (cacheable && hit_s) begin
        state_d = start_request ? DONE : IDLE;
        result_d = data_q[idx_s];
        hit_d = 1'b1;
        done_d = start_request;
      end else begin
        state_d = CS_SETUP;
        cs_d = 1'b0;
        sclk_d = 1'b0;
        mosi_d = tx_q[TXW-1];
        bit_d = '0;
      end
      CS_SETUP: begin
        state_d = SHIFT;
        sclk_d = 1'b1;
      end
      SHIFT: if (!sclk_q) sclk_d = 1'b1;
      else begin
        sclk_d = 1'b0;
        if (data_bit) byte_d = byte_in;
        if (data_bit && bit_q[2:0] == 3'd7) result_d = {byte_in, result_q[31:8]};
        if (last_bit) begin
          state_d = CS_END;
          cs_d = 1'b1;
          mosi_d = 1'b0;
        end else begin
          bit_d = bit_q + 1'b1;
          tx_d = tx_q << 1;
          mosi_d = tx_q[TXW-2];
        end
      end
      CS_END: begin
        result_d = rd_word;
        state_d = (start_request && !abort_q) ? DONE : IDLE;
        done_d = start_request && !abort_q;
        if (cacheable) begin
          valid_d[idx_s] = 1'b1;
          tag_d[idx_s] = tag_s;
          data_d[idx_s] = rd_word;
        end
        if (wr_q && hit_s) valid_d[idx_s] = 1'b0;
        if (wr_q && hit_e) valid_d[idx_e] = 1'b0;
      end
      DONE: if (!start_request) begin
        state_d = IDLE;
        done_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (cache_flush) valid_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_prev_q <= 1'b0;
      wr_q <= 1'b0;
      df_q <= 1'b0;
      abort_q <= 1'b0;
      cs_q <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      nm1_q <= 2'd0;
      addr_q <= '0;
      tx_q <= '0;
      bit_q <= '0;
      byte_q <= 8'h0;
      result_q <= 32'h0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      start_prev_q <= start_prev_d;
      wr_q <= wr_d;
      df_q <= df_d;
      abort_q <= abort_d;
      cs_q <= cs_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
      hit_q <= hit_d;
      nm1_q <= nm1_d;
      addr_q <= addr_d;
      tx_q <= tx_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      result_q <= result_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_spi_mem_ctrl_cached.sv
// tb_spi_mem_ctrl_cached: vector table driven through a queue scoreboard, with an
// SPI memory model answering reads and logging mosi; plus abort and reset corner cases.
module tb_spi_mem_ctrl_cached;
  logic clk = 1'b0, rst_n = 1'b0, miso, sclk, mosi, cs;
  logic start_request = 1'b0, is_write = 1'b0, is_data_fetch = 1'b0, cache_flush = 1'b0;
  logic [2:0] read_bytes = 3'd0;
  logic [23:0] target_address = 24'h0;
  logic [31:0] write_data = 32'h0, fetched_instruction, fetched_data;
  logic request_done, cache_hit;
  always #5 clk = ~clk;
  spi_mem_ctrl_cached dut (
    .clk(clk), .rst_n(rst_n), .miso(miso), .sclk(sclk), .mosi(mosi), .cs(cs),
    .start_request(start_request), .is_write(is_write), .is_data_fetch(is_data_fetch),
    .read_bytes(read_bytes), .target_address(target_address), .write_data(write_data),
    .fetched_instruction(fetched_instruction), .fetched_data(fetched_data),
    .request_done(request_done), .cache_flush(cache_flush), .cache_hit(cache_hit)
  );
  int checks = 0, failures = 0;
  logic [31:0] resp = 32'h0;
  int cnt = 0, mosi_n = 0;
  logic [71:0] mosi_log = 72'h0;
  // memory model: bit index counts completed sclk periods since cs fell
  always @(negedge sclk or posedge cs) cnt = cs ? 0 : cnt + 1;
  always @(posedge sclk) begin
    mosi_log = {mosi_log[70:0], mosi};
    mosi_n = mosi_n + 1;
  end
  always_comb begin
    int k;
    k = (cnt >= 32 && cnt < 64) ? cnt - 32 : 0;
    miso = (!cs && cnt >= 32 && cnt < 64) ? resp[(k / 8) * 8 + 7 - k % 8] : 1'b0;
  end
  typedef struct {
    logic hit;
    int lat;
    logic [31:0] ins, dat;
    logic [71:0] mo;
    int bits;
  } exp_t;
  typedef struct {
    logic wr, df;
    logic [2:0] nb;
    logic [23:0] addr;
    logic [31:0] wd, rsp;
    logic pf;
    int fa;
    exp_t e;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[$];
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic wr, input logic df, input logic [2:0] nb, input logic [23:0] addr,
                              input logic [31:0] wd, input logic [31:0] rsp, input logic pf, input int fa,
                              input logic hit, input logic [31:0] ins, input logic [31:0] dat, input logic [71:0] mo);
    vec_t v;
    int n;
    n = (nb == 3'd0 || nb > 3'd4) ? 4 : int'(nb);
    v.wr = wr; v.df = df; v.nb = nb; v.addr = addr; v.wd = wd; v.rsp = rsp; v.pf = pf; v.fa = fa;
    v.e.hit = hit; v.e.ins = ins; v.e.dat = dat; v.e.mo = mo;
    v.e.bits = hit ? 0 : 32 + 8 * n;
    v.e.lat = hit ? 2 : 2 + 2 * (32 + 8 * n) + 1;
    return v;
  endfunction
  task automatic run(input vec_t v, input string tg);
    int lat, base;
    logic cs_low, hit_seen;
    exp_t e;
    if (v.pf) begin
      @(posedge clk); #1 cache_flush = 1'b1;
      @(posedge clk); #1 cache_flush = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    resp = v.rsp; is_write = v.wr; is_data_fetch = v.df; read_bytes = v.nb;
    target_address = v.addr; write_data = v.wd; base = mosi_n;
    start_request = 1'b1;
    sb.push_back(v.e);
    lat = 0; cs_low = 1'b0; hit_seen = 1'b0;
    while (lat < 400) begin
      @(posedge clk); lat++;
      #1 cache_flush = (lat == v.fa);
      @(negedge clk);
      if (!cs) cs_low = 1'b1;
      if (cache_hit) hit_seen = 1'b1;
      if (request_done) break;
    end
    cache_flush = 1'b0;
    e = sb.pop_front();
    chk({tg, " done"}, 72'(request_done), 72'd1);
    chk({tg, " latency"}, 72'(lat), 72'(e.lat));
    chk({tg, " cache_hit"}, 72'(hit_seen), 72'(e.hit));
    chk({tg, " spi_active"}, 72'(cs_low), 72'(!e.hit));
    chk({tg, " fetched_instruction"}, 72'(fetched_instruction), 72'(e.ins));
    chk({tg, " fetched_data"}, 72'(fetched_data), 72'(e.dat));
    chk({tg, " mosi_bits"}, 72'(mosi_n - base), 72'(e.bits));
    chk({tg, " mosi"}, mosi_log & ((72'd1 << e.bits) - 72'd1), e.mo);
    repeat (2) @(negedge clk);
    chk({tg, " done_hold"}, 72'(request_done), 72'd1);
    chk({tg, " hit_pulse_end"}, 72'(cache_hit), 72'd0);
    @(posedge clk); #1 start_request = 1'b0;
    @(negedge clk);
    chk({tg, " outputs_idle"}, {8'h0, fetched_instruction, fetched_data}, 72'h0);
    @(negedge clk);
    chk({tg, " done_clear"}, 72'(request_done), 72'd0);
  endtask
  initial begin
    logic seen;
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'h00000513, 0, -1, 0, 32'h00000513, 0, 72'h0300010000000000));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'hFFFFFFFF, 0, -1, 1, 32'h00000513, 0, 72'h0));
    vecs.push_back(mk(1, 1, 2, 24'h000102, 32'h0000BEEF, 0, 0, -1, 0, 0, 0, 72'h02000102EFBE));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'hDEAD0513, 0, -1, 0, 32'hDEAD0513, 0, 72'h0300010000000000));
    vecs.push_back(mk(0, 1, 1, 24'h000203, 0, 32'h776655A5, 0, -1, 0, 0, 32'h000000A5, 72'h0300020300));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'h0, 0, -1, 1, 32'hDEAD0513, 0, 72'h0));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'hCAFE0513, 1, -1, 0, 32'hCAFE0513, 0, 72'h0300010000000000));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'h0, 0, -1, 1, 32'hCAFE0513, 0, 72'h0));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'h0BAD0513, 1, 130, 0, 32'h0BAD0513, 0, 72'h0300010000000000));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'h0BAD0513, 0, -1, 0, 32'h0BAD0513, 0, 72'h0300010000000000));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'h0, 0, -1, 1, 32'h0BAD0513, 0, 72'h0));
    vecs.push_back(mk(0, 0, 4, 24'h000104, 0, 32'h11223344, 0, -1, 0, 32'h11223344, 0, 72'h0300010400000000));
    vecs.push_back(mk(0, 0, 4, 24'h000104, 0, 32'h0, 0, -1, 1, 32'h11223344, 0, 72'h0));
    vecs.push_back(mk(1, 1, 4, 24'h000103, 32'hA1B2C3D4, 0, 0, -1, 0, 0, 0, 72'h02000103D4C3B2A1));
    vecs.push_back(mk(0, 0, 4, 24'h000104, 0, 32'h55667788, 0, -1, 0, 32'h55667788, 0, 72'h0300010400000000));
    vecs.push_back(mk(0, 0, 4, 24'h000100, 0, 32'h99AABBCC, 0, -1, 0, 32'h99AABBCC, 0, 72'h0300010000000000));
    vecs.push_back(mk(0, 0, 0, 24'h000108, 0, 32'h01020304, 0, -1, 0, 32'h01020304, 0, 72'h0300010800000000));
    vecs.push_back(mk(0, 0, 4, 24'h000108, 0, 32'h0, 0, -1, 1, 32'h01020304, 0, 72'h0));
    vecs.push_back(mk(0, 0, 4, 24'h000000, 0, 32'h13131313, 0, -1, 0, 32'h13131313, 0, 72'h0300000000000000));
    vecs.push_back(mk(1, 1, 2, 24'hFFFFFF, 32'h00001234, 0, 0, -1, 0, 0, 0, 72'h02FFFFFF3412));
    vecs.push_back(mk(0, 0, 4, 24'h000000, 0, 32'h24242424, 0, -1, 0, 32'h24242424, 0, 72'h0300000000000000));
    vecs.push_back(mk(0, 1, 7, 24'h000300, 0, 32'h89ABCDEF, 0, -1, 0, 0, 32'h89ABCDEF, 72'h0300030000000000));
    vecs.push_back(mk(0, 0, 4, 24'h000300, 0, 32'h10101010, 0, -1, 0, 32'h10101010, 0, 72'h0300030000000000));
    repeat (3) @(posedge clk);
    #1;
    chk("reset cs", 72'(cs), 72'd1);
    chk("reset sclk_mosi", 72'({sclk, mosi}), 72'd0);
    chk("reset done_hit", 72'({request_done, cache_hit}), 72'd0);
    chk("reset outputs", {8'h0, fetched_instruction, fetched_data}, 72'h0);
    rst_n = 1'b1;
    foreach (vecs[i]) run(vecs[i], $sformatf("v%0d", i));
    // start drops mid-transfer: SPI completes but request_done must never rise
    @(posedge clk); #1;
    is_write = 1'b0; is_data_fetch = 1'b0; read_bytes = 3'd4; target_address = 24'h00010C;
    resp = 32'h77777777; start_request = 1'b1;
    repeat (20) @(posedge clk);
    #1 start_request = 1'b0;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (request_done) seen = 1'b1;
    end
    chk("abort no_done", 72'(seen), 72'd0);
    chk("abort cs_released", 72'(cs), 72'd1);
    run(mk(0, 0, 4, 24'h000104, 0, 32'h0, 0, -1, 1, 32'h55667788, 0, 72'h0), "after_abort");
    // asynchronous reset in the middle of a shift
    @(posedge clk); #1;
    target_address = 24'h000200; resp = 32'h0; start_request = 1'b1;
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset cs", 72'(cs), 72'd1);
    chk("midreset sclk", 72'(sclk), 72'd0);
    start_request = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run(mk(0, 0, 4, 24'h000104, 0, 32'h55667788, 0, -1, 0, 32'h55667788, 0, 72'h0300010400000000), "after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_mem_ctrl_cached.md
Name: spi_mem_ctrl_cached

Overview:
SPI-flash/SRAM memory controller for the RV32E core, and the next generation of the single-channel read-only SPI fetch path. It issues READ (0x03) and WRITE (0x02) transactions of 1-4 bytes with a parametrised address width. A direct-mapped instruction cache serves aligned word fetches without SPI traffic. It sits between the core's fetch/load-store unit and the external SPI memory pins.

Parameters:
ADDR_W, 24, SPI address width in bits (multiple of 8).
CACHE_LINES, 8, number of direct-mapped one-word lines (power of 2, >=2).
CMD_READ, 8'h03, SPI read opcode.
CMD_WRITE, 8'h02, SPI write opcode.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
miso  input  1  SPI data from memory
sclk  output  1  SPI clock, mode 0, clk/2
mosi  output  1  SPI data to memory
cs  output  1  SPI chip select, active low
start_request  input  1  request level; rising edge starts an operation
is_write  input  1  1 = write, 0 = read
is_data_fetch  input  1  1 = load/store, 0 = instruction fetch
read_bytes  input  3  byte count 1-4; 0 and 5-7 are treated as 4
target_address  input  ADDR_W  byte address
write_data  input  32  store data, byte 0 in [7:0]
fetched_instruction  output  32  read result for instruction fetch
fetched_data  output  32  read result for data fetch
request_done  output  1  operation complete
cache_flush  input  1  invalidate all lines
cache_hit  output  1  one-cycle pulse on cache hit

Behaviour:
- Reset (async): cs=1, sclk=0, mosi=0, request_done=0, cache_hit=0, result register=0, all valid bits=0, FSM=IDLE.
- FSM states: IDLE, LOOKUP, CS_SETUP, SHIFT, CS_END, DONE.
- IDLE: a start is taken when start_request=1 and it was 0 in the previous cycle. All request inputs are captured on this cycle and held for the whole operation.
- LOOKUP (1 cycle): a request is cacheable when it is a read, is_data_fetch=0, byte count=4 and address[1:0]=0. A cacheable request whose line is valid with a matching tag goes to DONE. It loads the line, pulses cache_hit and makes no SPI activity. Every other request goes to CS_SETUP.
- Cache index = address[2+log2(CACHE_LINES)-1:2]. Tag = the remaining upper address bits.
- CS_SETUP (1 cycle): cs=0, sclk=0, mosi = first bit.
- SHIFT covers 8 + ADDR_W + 8*n bits, MSB first per byte. The order is command, address, then data bytes in order byte0..byte(n-1).
- Each bit takes 2 clks:
  - phase 0: sclk=0, mosi updated;
  - phase 1: sclk=1, miso sampled.
- Read bytes are assembled little-endian (first byte -> [7:0]). Unread upper bytes are 0.
- During read data bits, mosi=0.
- CS_END (1 cycle): sclk=0, cs=1.
- Miss latency from the start edge: 2 + 2*(8+ADDR_W+8n) + 1 cycles until request_done. That is 131 cycles for ADDR_W=24, n=4.
- Hit latency: request_done is high 2 cycles after the start edge.
- DONE: request_done=1 while start_request stays 1. It clears, and the FSM returns to IDLE, the cycle after start_request falls.
- If start_request falls before completion, the SPI transaction still runs to CS_END and then returns straight to IDLE. request_done never asserts in that case.
- Output muxing:
  - fetched_instruction = result when start_request=1 and is_data_fetch=0, else 0;
  - fetched_data = result when start_request=1 and is_data_fetch=1, else 0;
  - both outputs are 0 for writes.
- Fill: a cacheable miss writes data, tag and valid on the CS_END cycle.
- Coherence: a write invalidates the lines covering target_address and (target_address+n-1), when valid with a matching tag, on its CS_END cycle.
- cache_flush (1 cycle): clears all valid bits. It has priority over a fill or invalidate in the same cycle. It is legal in any state and does not disturb an SPI transaction in progress.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- Cold fetch at 0x000100 with miso bytes 13 05 00 00 -> mosi shows 03 00 01 00, then fetched_instruction=0x00000513, request_done at cycle 131, cache_hit=0.
- Repeat the fetch at 0x000100 -> cache_hit pulse, request_done 2 cycles after the edge, cs stays 1, fetched_instruction=0x00000513.
- Write of 2 bytes to 0x000102 with write_data=0x0000BEEF -> mosi 02 00 01 02 EF BE. Then refetch 0x000100 -> miss with full SPI read.
- Data read of 1 byte at 0x000203 with miso=0xA5 -> fetched_data=0x000000A5, fetched_instruction=0, no line filled.
- Fill 0x000100, pulse cache_flush, refetch -> miss. Flush coincident with a fill cycle -> line stays invalid.
- Assert rst_n low mid-SHIFT -> cs=1, sclk=0 immediately. The next request starts cleanly and a previously cached address misses.
